mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encodings and
// the default memory depth.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam int MEM_DEPTH_DEFAULT = 101;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational. The caller owns the
// last_grant register (0 = master 0 won last, 1 = master 1 won last).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Lone requester wins; on a tie the master that did not win last time goes
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter and SETUP/ACCESS sequencer for the single-port data memory.
// Optional MEM_ARB_ADDR_CHECK_EN: out-of-range addresses complete at once with err=1.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_paddr,
    output logic              mem_we,
    output logic              mem_penable,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_DEPTH < 1) begin : g_bad_depth
        $error("mem_arbiter: MEM_DEPTH must be at least 1");
    end

    arb_state_t        state_r, state_s;
    logic              last_grant_r, last_grant_s;
    logic              win_r, win_s;
    logic [1:0]        grant_s;
    logic [ADDR_W-1:0] sel_addr_s, paddr_r, paddr_s;
    logic              sel_we_s, we_r, we_s;
    logic [DATA_W-1:0] sel_wdata_s, wdata_r, wdata_s;
    logic              penable_r, penable_s;
    logic [1:0]        ack_r, ack_s;
    logic [1:0]        err_r, err_s;
    logic [1:0]        pass_r, pass_s;
    logic [DATA_W-1:0] rdata0_r, rdata1_r;
    logic              addr_bad_s;

    rr_arb2 u_rr_arb2 (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    assign sel_addr_s  = grant_s[1] ? m1_addr  : m0_addr;
    assign sel_we_s    = grant_s[1] ? m1_we    : m0_we;
    assign sel_wdata_s = grant_s[1] ? m1_wdata : m0_wdata;

`ifdef MEM_ARB_ADDR_CHECK_EN
    assign addr_bad_s = (sel_addr_s >= ADDR_W'(MEM_DEPTH));
`else
    assign addr_bad_s = 1'b0;
`endif

    // Next-state and next-output decode; every output is registered from these
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        win_s        = win_r;
        paddr_s      = paddr_r;
        we_s         = we_r;
        wdata_s      = wdata_r;
        penable_s    = 1'b0;
        ack_s        = 2'b00;
        err_s        = 2'b00;
        pass_s       = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    win_s        = grant_s[1];
                    last_grant_s = grant_s[1];
                    if (addr_bad_s) begin
                        state_s = ST_DONE;
                        ack_s   = grant_s;
                        err_s   = grant_s;
                    end else begin
                        state_s = ST_SETUP;
                        paddr_s = sel_addr_s;
                        we_s    = sel_we_s;
                        wdata_s = sel_wdata_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s   = ST_ACCESS;
                penable_s = 1'b1;
            end
            ST_ACCESS: begin
                state_s = ST_DONE;
                we_s    = 1'b0;
                ack_s   = win_r ? 2'b10 : 2'b01;
                // read data arrives from the memory register during DONE
                pass_s  = we_r ? 2'b00 : (win_r ? 2'b10 : 2'b01);
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            win_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            win_r        <= win_s;
        end
    end

    // Registered memory-side and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddr_r   <= '0;
            we_r      <= 1'b0;
            wdata_r   <= '0;
            penable_r <= 1'b0;
            ack_r     <= 2'b00;
            err_r     <= 2'b00;
            pass_r    <= 2'b00;
        end else begin
            paddr_r   <= paddr_s;
            we_r      <= we_s;
            wdata_r   <= wdata_s;
            penable_r <= penable_s;
            ack_r     <= ack_s;
            err_r     <= err_s;
            pass_r    <= pass_s;
        end
    end

    // Per-master read data holding registers, captured at the end of DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else begin
            rdata0_r <= pass_r[0] ? mem_rdata : rdata0_r;
            rdata1_r <= pass_r[1] ? mem_rdata : rdata1_r;
        end
    end

    assign mem_paddr   = paddr_r;
    assign mem_we      = we_r;
    assign mem_wdata   = wdata_r;
    assign mem_penable = penable_r;
    assign m0_ack      = ack_r[0];
    assign m1_ack      = ack_r[1];
    assign m0_err      = err_r[0];
    assign m1_err      = err_r[1];
    assign m0_rdata    = pass_r[0] ? mem_rdata : rdata0_r;
    assign m1_rdata    = pass_r[1] ? mem_rdata : rdata1_r;

endmodule
